// File: rtl/sap1_sequencer.sv
// sap1_sequencer: SAP-1 six-phase T-state sequencer with opcode decode, halt and single-step control.
module sap1_sequencer #(
    parameter logic [11:0] CW_DEFAULT = 12'h3E3,
    parameter int          CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ir_opcode,
    input  logic             step_mode,
    input  logic             step_req,
    output logic [2:0]       t_state,
    output logic [5:0]       counter_out,
    output logic [11:0]      controlword,
    output logic             halted,
    output logic             waiting,
    output logic [CNT_W-1:0] instr_cnt
);
    typedef enum logic [2:0] {
        S_WAIT = 3'd0, S_T1 = 3'd1, S_T2 = 3'd2, S_T3 = 3'd3,
        S_T4 = 3'd4, S_T5 = 3'd5, S_T6 = 3'd6, S_HALT = 3'd7
    } state_t;
    state_t state;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_WAIT;
            instr_cnt <= '0;
        end else begin
            case (state)
                S_WAIT: state <= (!step_mode || step_req) ? S_T1 : S_WAIT;
                S_T1:   state <= S_T2;
                S_T2:   state <= S_T3;
                S_T3:   state <= S_T4;
                S_T4:   state <= (ir_opcode == 4'hF) ? S_HALT : S_T5;
                S_T5:   state <= S_T6;
                S_T6: begin
                    state     <= step_mode ? S_WAIT : S_T1;
                    instr_cnt <= instr_cnt + CNT_W'(1);
                end
                default: state <= S_HALT;
            endcase
        end
    end
    assign t_state     = state;
    assign waiting     = state == S_WAIT;
    assign halted      = state == S_HALT;
    assign counter_out = (state == S_WAIT || state == S_HALT) ? 6'd0 : 6'd1 << (state - 3'd1);
    // Execute phases: 0..2 share the memory-read T4, ADD/SUB share the B-load T5.
    always_comb begin
        controlword = CW_DEFAULT;
        case (state)
            S_T1: controlword = 12'h5E3;
            S_T2: controlword = 12'hBE3;
            S_T3: controlword = 12'h263;
            S_T4: controlword = (ir_opcode == 4'hE) ? 12'h3F2 :
                                (ir_opcode <= 4'h2) ? 12'h1A3 : CW_DEFAULT;
            S_T5: controlword = (ir_opcode == 4'h0) ? 12'h2C3 :
                                (ir_opcode == 4'h1 || ir_opcode == 4'h2) ? 12'h2E1 : CW_DEFAULT;
            S_T6: controlword = (ir_opcode == 4'h1) ? 12'h3C7 :
                                (ir_opcode == 4'h2) ? 12'h3CF : CW_DEFAULT;
            default: controlword = CW_DEFAULT;
        endcase
    end
endmodule

// File: doc/sap1_sequencer.md
# sap1_sequencer

Controller-sequencer for the SAP-1 CPU datapath. Steps a six-phase T-state machine (T1..T6), decodes the 4-bit opcode held in the instruction register into the 12-bit active-low/active-high control word that drives PC, MAR, RAM, IR, accumulator, ALU, B and output registers, and adds halt and single-step run control. Sits between the IR opcode nibble and every load/enable pin on the bus.

## Interface
Parameters:
- CW_DEFAULT, 12'h3E3, idle (all-inactive) control word
- CNT_W, 8, width of retired-instruction counter

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous reset, active-high
- ir_opcode  input  4  IR upper nibble; stable from end of T3 through T6
- step_mode  input  1  1 = single-step, 0 = free-run
- step_req  input  1  level-sampled request to run one instruction (step mode only)
- t_state  output  3  0=WAIT, 1..6=T1..T6, 7=HALT
- counter_out  output  6  one-hot ring: bit0=T1 .. bit5=T6; 0 in WAIT/HALT
- controlword  output  12  {cp,ep,lm_n,ce_n,li_n,ei_n,la_n,ea,su,eu,lb_n,lo_n}, bit 11 = cp
- halted  output  1  HLT executed
- waiting  output  1  sequencer in WAIT
- instr_cnt  output  CNT_W  retired instructions, wraps

## Operation
- Reset (async, immediate): t_state=WAIT, counter_out=0, controlword=CW_DEFAULT, halted=0, waiting=1, instr_cnt=0.
- Transitions (one per clock edge): WAIT→T1 if !step_mode or step_req, else stay; T1→T2→T3→T4; T4→HALT if ir_opcode==4'hF else T5; T5→T6; T6→T1 if !step_mode else WAIT; HALT→HALT until rst.
- instr_cnt increments on T6 exit only (HLT never counts); CNT_W-bit wrap, all-ones+1 → 0.
- controlword is combinational from registered t_state and ir_opcode; no output register stage.
- Fetch (all opcodes): T1 12'h5E3 (ep, lm_n); T2 12'hBE3 (cp); T3 12'h263 (ce_n, li_n).
- LDA 4'h0: T4 12'h1A3 (ei_n, lm_n); T5 12'h2C3 (ce_n, la_n); T6 12'h3E3.
- ADD 4'h1: T4 12'h1A3; T5 12'h2E1 (ce_n, lb_n); T6 12'h3C7 (la_n, eu).
- SUB 4'h2: T4 12'h1A3; T5 12'h2E1; T6 12'h3CF (la_n, su, eu).
- OUT 4'hE: T4 12'h3F2 (ea, lo_n); T5, T6 12'h3E3.
- HLT 4'hF: T4 12'h3E3; next state HALT.
- Undefined opcodes: T4..T6 12'h3E3 (NOP), counted as retired.
- WAIT and HALT: controlword=CW_DEFAULT, counter_out=0.
- halted asserts from first HALT cycle; waiting high exactly in WAIT.

## Timing
- Free-run instruction period 6 clocks; first T1 one clock after rst deasserts (one WAIT cycle).
- Step mode: period 6 clocks + WAIT cycles; step_req sampled only in WAIT; held-high step_req runs back-to-back instructions with one WAIT cycle between.
- step_mode changes take effect at next WAIT or T6 decision; never abort an instruction mid-phase.
- ir_opcode read only in T4..T6; changes during T1..T3 have no effect.
- HLT: halted=1 at edge ending T4; HALT exits only via rst.
- rst mid-instruction: outputs return to reset values immediately, no further control pulses.

## Test plan
- Free-run LDA (ir_opcode=0): after rst release, t_state 0,1..6,1; controlword 3E3,5E3,BE3,263,1A3,2C3,3E3; instr_cnt=1 after T6.
- ADD then SUB: T5=2E1 both, T6=3C7 for ADD and 3CF for SUB; counter_out one-hot 01,02,04,08,10,20 each instruction.
- OUT then HLT: OUT T4=3F2; HLT T4=3E3, t_state=7, halted=1 held for 20 clocks, instr_cnt unchanged by HLT.
- Step mode, step_req=0 for 10 clocks: waiting=1, controlword=3E3; one-cycle step_req pulse → exactly one instruction, back to WAIT, instr_cnt+1.
- instr_cnt wrap: 256 NOP (opcode 4'h5) instructions from reset → instr_cnt=0.
- rst asserted in T5 of ADD: same-cycle t_state=0, controlword=3E3, counter_out=0, instr_cnt=0.
